// File: rtl/uart_pkg.sv
// Shared types for the UART receive controller.
// Holds the controller state encoding and the per-frame error bundle.
package uart_pkg;

    typedef enum logic [1:0] {
        OFF = 2'd0,
        ARM = 2'd1,
        RUN = 2'd2
    } rx_ctrl_state_e;

    typedef struct packed {
        logic frame;
        logic parity;
    } rx_err_t;

    localparam logic [15:0] DEFAULT_DIV = 16'd53;

endpackage

// File: rtl/uart_rx_ctrl_if.sv
// Receive stream between the controller FIFO head and its consumer.
// The master presents data/err/valid and the slave returns ready.
interface uart_rx_ctrl_if
    import uart_pkg::*;
#(
    parameter int DATA_BITS = 8
) ();

    logic [DATA_BITS-1:0] m_data;
    rx_err_t              m_err;
    logic                 m_valid;
    logic                 m_ready;

    modport master (
        output m_data,
        output m_err,
        output m_valid,
        input  m_ready
    );

    modport slave (
        input  m_data,
        input  m_err,
        input  m_valid,
        output m_ready
    );

endinterface

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through synchronous FIFO with occupancy count.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module uart_rx_fifo #(
    parameter int  W     = 10,
    parameter int  DEPTH = 8,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          push_i,
    input  logic [W-1:0]  wdata_i,
    input  logic          ready_i,
    output logic [W-1:0]  rdata_o,
    output logic          valid_o,
    output logic [CW-1:0] count_o,
    output logic          accept_o
);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wptr_q;
    logic [AW-1:0] rptr_q;
    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;
    logic          full;
    logic          pop;
    logic          wr;

    assign full     = (count_q == CW'(DEPTH));
    assign valid_o  = (count_q != '0);
    assign pop      = valid_o & ready_i;
    assign wr       = push_i & (~full | pop);
    assign accept_o = wr;
    assign count_o  = count_q;
    // Head is forced to zero when empty so reset clears the visible stream.
    assign rdata_o  = valid_o ? mem_q[rptr_q] : '0;

    always_comb begin
        count_d = count_q;
        unique case ({wr, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (wr) mem_q[wptr_q] <= wdata_i;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (wr)  wptr_q <= wptr_q + 1'b1;
            if (pop) rptr_q <= rptr_q + 1'b1;
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: baud tick, idle-gated arming, frame FIFO, status.
// Define UART_RX_CTRL_DROP_BAD_EN to drop errored frames and count them on bad_cnt.
module uart_rx_ctrl
    import uart_pkg::*;
#(
    parameter int  DATA_BITS  = 8,
    parameter int  FIFO_DEPTH = 8,
    parameter int  DIV_W      = 16,
    parameter int  IDLE_TICKS = 16,
    localparam int CW         = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 enable,
    input  logic [DIV_W-1:0]     baud_div,
    input  logic                 parity_cfg,
    input  logic                 rx_pin,
    output logic                 tick_16x,
    output logic                 parity_enable,
    input  logic [DATA_BITS-1:0] rx_data_in,
    input  logic                 rx_ready_in,
    input  logic                 rx_perr_in,
    input  logic                 rx_ferr_in,
    uart_rx_ctrl_if.master       m_if,
    output logic [CW-1:0]        fifo_count,
    input  logic                 clr_status,
    output logic                 sts_perr,
    output logic                 sts_ferr,
    output logic                 sts_overrun
`ifdef UART_RX_CTRL_DROP_BAD_EN
    ,
    output logic [7:0]           bad_cnt
`endif
);

    localparam int IW = $clog2(IDLE_TICKS + 1);
    localparam logic [IW-1:0] IDLE_LIM = IW'(IDLE_TICKS);

    rx_ctrl_state_e state_q, state_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic             par_q, par_d;
    logic [IW-1:0]    idle_q, idle_d;
    logic [IW-1:0]    idle_inc;
    logic             rdy_q;
    logic             perr_q, ferr_q, ovr_q;
    logic             tick;
    logic             push_frame;
    logic             bad;
    logic             fifo_push;
    logic             fifo_acc;
    logic             err_ev;
    logic [DATA_BITS+1:0] fifo_rd;

    assign tick     = (state_q != OFF) && (cnt_q == div_q);
    assign idle_inc = idle_q + 1'b1;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        div_d   = div_q;
        par_d   = par_q;
        idle_d  = idle_q;
        if (state_q == OFF || !enable) cnt_d = '0;
        else                           cnt_d = tick ? '0 : cnt_q + 1'b1;
        unique case (state_q)
            OFF: begin
                if (enable) begin
                    div_d   = baud_div;
                    par_d   = parity_cfg;
                    idle_d  = '0;
                    state_d = ARM;
                end
            end
            ARM: begin
                if (!enable) begin
                    state_d = OFF;
                end else if (tick) begin
                    idle_d = rx_pin ? idle_inc : '0;
                    if (rx_pin && idle_inc == IDLE_LIM) state_d = RUN;
                end
            end
            RUN: begin
                if (!enable) state_d = OFF;
            end
            default: state_d = OFF;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= OFF;
            cnt_q   <= '0;
            div_q   <= '0;
            par_q   <= 1'b0;
            idle_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            div_q   <= div_d;
            par_q   <= par_d;
            idle_q  <= idle_d;
        end
    end

    // data_ready is held for a whole tick period; only its first clk counts.
    assign push_frame = rx_ready_in & ~rdy_q & (state_q == RUN);
    assign bad        = rx_perr_in | rx_ferr_in;

`ifdef UART_RX_CTRL_DROP_BAD_EN
    assign fifo_push = push_frame & ~bad;
    assign err_ev    = push_frame;
`else
    assign fifo_push = push_frame;
    assign err_ev    = fifo_acc;
`endif

    uart_rx_fifo #(
        .W     (DATA_BITS + 2),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset_n  (reset_n),
        .push_i   (fifo_push),
        .wdata_i  ({rx_ferr_in, rx_perr_in, rx_data_in}),
        .ready_i  (m_if.m_ready),
        .rdata_o  (fifo_rd),
        .valid_o  (m_if.m_valid),
        .count_o  (fifo_count),
        .accept_o (fifo_acc)
    );

    assign m_if.m_data = fifo_rd[DATA_BITS-1:0];
    assign m_if.m_err  = rx_err_t'(fifo_rd[DATA_BITS+1:DATA_BITS]);

    // A new event in the same cycle as clr_status survives the clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rdy_q  <= 1'b0;
            perr_q <= 1'b0;
            ferr_q <= 1'b0;
            ovr_q  <= 1'b0;
        end else begin
            rdy_q  <= rx_ready_in;
            perr_q <= (err_ev & rx_perr_in) | (perr_q & ~clr_status);
            ferr_q <= (err_ev & rx_ferr_in) | (ferr_q & ~clr_status);
            ovr_q  <= (fifo_push & ~fifo_acc) | (ovr_q & ~clr_status);
        end
    end

`ifdef UART_RX_CTRL_DROP_BAD_EN
    logic [7:0] bad_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bad_q <= '0;
        end else if (push_frame && bad) begin
            if (clr_status)          bad_q <= 8'd1;
            else if (bad_q != 8'hFF) bad_q <= bad_q + 8'd1;
        end else if (clr_status) begin
            bad_q <= '0;
        end
    end

    assign bad_cnt = bad_q;
`endif

    assign tick_16x      = tick;
    assign parity_enable = par_q;
    assign sts_perr      = perr_q;
    assign sts_ferr      = ferr_q;
    assign sts_overrun   = ovr_q;

endmodule
